select_sequencer: RTL and testbench

- Controller that executes the WebAssembly parametric operators `drop` (0x1A) and `select` (0x1B) against the CPU operand stack.
- Accepts one opcode at a time from the decode stage and sequences stack pops, the condition test and the result push.
- Reports completion or a trap code to the CPU core.
- Sits between decode and the operand stack as the stack's sole master while an op is in flight.

---
 rtl/select_sequencer_if.sv | 27 ++
 rtl/select_sequencer.sv | 147 ++++++++++++++
 tb/tb_select_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/select_sequencer_if.sv
// Decode handshake and operand-stack bus for select_sequencer.
// The master modport is the sequencer side; slave is the decode/stack side.
interface select_sequencer_if #(
  parameter int STACK_ADDR = 4,
  parameter int DATA_W     = 64
);
  logic                  op_valid;
  logic                  op_ready;
  logic [7:0]            opcode;
  logic                  done;
  logic [2:0]            trap;
  logic [STACK_ADDR:0]   stack_size;
  logic                  stack_pop;
  logic [DATA_W-1:0]     stack_dout;
  logic                  stack_push;
  logic [DATA_W-1:0]     stack_din;

  modport master (
    input  op_valid, opcode, stack_size, stack_dout,
    output op_ready, done, trap, stack_pop, stack_push, stack_din
  );

  modport slave (
    output op_valid, opcode, stack_size, stack_dout,
    input  op_ready, done, trap, stack_pop, stack_push, stack_din
  );
endinterface

// File: rtl/select_sequencer.sv
// Sequencer for the WebAssembly drop (0x1A) and select (0x1B) operators on the operand stack.
// Optional macro SELECT_TRAP_CLEAR_EN adds a trap_clear input that leaves the sticky TRAP state.
module select_sequencer #(
  parameter int STACK_ADDR = 4,
  parameter int DATA_W     = 64
) (
  input  logic clk,
  input  logic reset,
`ifdef SELECT_TRAP_CLEAR_EN
  input  logic trap_clear,
`endif
  select_sequencer_if.master bus
);
  localparam logic [7:0] OP_DROP   = 8'h1A;
  localparam logic [7:0] OP_SELECT = 8'h1B;

  typedef enum logic [2:0] {
    IDLE, CHECK, POP_V2, POP_V1, LATCH_V1, PUSH, DROP_WAIT, TRAP
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          opcode_q, opcode_d;
  logic [31:0]         cond_q, cond_d;
  logic [DATA_W-1:0]   v1_q, v1_d;
  logic [DATA_W-1:0]   v2_q, v2_d;
  logic [2:0]          trap_q, trap_d;
  logic                done_q, done_d;
  logic                push_q, push_d;
  logic                ready_q, ready_d;
  logic                pop;
  logic                is_drop, is_select, underflow;

  assign is_drop   = (opcode_q == OP_DROP);
  assign is_select = (opcode_q == OP_SELECT);
  assign underflow = (is_select && (bus.stack_size < (STACK_ADDR+1)'(3))) ||
                     (is_drop   && (bus.stack_size < (STACK_ADDR+1)'(1)));

  // The condition is an i32, so only its low word is kept.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cond_d   = cond_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    trap_d   = trap_q;
    done_d   = 1'b0;
    push_d   = 1'b0;
    ready_d  = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.op_valid) begin
          opcode_d = bus.opcode;
          ready_d  = 1'b0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (!is_drop && !is_select) begin
          trap_d  = 3'd5;
          state_d = TRAP;
        end else if (underflow) begin
          trap_d  = 3'd3;
          state_d = TRAP;
        end else begin
          pop = 1'b1;
          if (is_drop) begin
            done_d  = 1'b1;
            state_d = DROP_WAIT;
          end else begin
            state_d = POP_V2;
          end
        end
      end
      DROP_WAIT: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      POP_V2: begin
        cond_d  = bus.stack_dout[31:0];
        pop     = 1'b1;
        state_d = POP_V1;
      end
      POP_V1: begin
        v2_d    = bus.stack_dout;
        pop     = 1'b1;
        state_d = LATCH_V1;
      end
      LATCH_V1: begin
        v1_d    = bus.stack_dout;
        push_d  = 1'b1;
        done_d  = 1'b1;
        state_d = PUSH;
      end
      PUSH: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      TRAP: begin
`ifdef SELECT_TRAP_CLEAR_EN
        if (trap_clear) begin
          trap_d  = 3'd0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      cond_q   <= '0;
      v1_q     <= '0;
      v2_q     <= '0;
      trap_q   <= '0;
      done_q   <= 1'b0;
      push_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cond_q   <= cond_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      trap_q   <= trap_d;
      done_q   <= done_d;
      push_q   <= push_d;
      ready_q  <= ready_d;
    end
  end

  // Pop in CHECK depends on stack_size seen that same cycle, so it stays combinational.
  assign bus.stack_pop  = pop;
  assign bus.stack_push = push_q;
  assign bus.done       = done_q;
  assign bus.trap       = trap_q;
  assign bus.op_ready   = ready_q;
  assign bus.stack_din  = (state_q == PUSH) ? ((cond_q != 32'd0) ? v1_q : v2_q) : '0;
endmodule

// File: tb/tb_select_sequencer.sv
// Testbench for select_sequencer: table vectors, hand sequences and random ops
// against a stack memory and an operator-level reference model.
module tb_select_sequencer;
  localparam int STACK_ADDR = 4;
  localparam int DATA_W     = 64;

  logic clk = 1'b0;
  logic reset;
`ifdef SELECT_TRAP_CLEAR_EN
  logic trap_clear;
`endif

  select_sequencer_if #(.STACK_ADDR(STACK_ADDR), .DATA_W(DATA_W)) bus();

  select_sequencer #(.STACK_ADDR(STACK_ADDR), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef SELECT_TRAP_CLEAR_EN
    .trap_clear (trap_clear),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    int          size;
    logic [63:0] e0;
    logic [63:0] e1;
    logic [63:0] e2;
    int          kind;
    logic [2:0]  tc;
    logic [63:0] din;
    int          pulseK;
  } vec_t;

  vec_t        vecs[9];
  logic [63:0] stk[$];
  int          compared   = 0;
  int          mismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stack memory: pops/pushes seen in a cycle take effect just after the closing edge.
  task automatic tick();
    logic p, u;
    logic [63:0] d;
    p = bus.stack_pop;
    u = bus.stack_push;
    d = bus.stack_din;
    @(posedge clk);
    #1;
    if (p) begin
      if (stk.size() > 0) bus.stack_dout = stk.pop_front();
      else bus.stack_dout = '0;
    end
    if (u) stk.push_front(d);
    bus.stack_size = (STACK_ADDR+1)'(stk.size());
    #1;
  endtask

  task automatic loadStack(input int size, input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2);
    stk.delete();
    for (int i = 0; i < size; i++) begin
      if (i == 0) stk.push_back(e0);
      else if (i == 1) stk.push_back(e1);
      else if (i == 2) stk.push_back(e2);
      else stk.push_back({$urandom, $urandom});
    end
    bus.stack_size = (STACK_ADDR+1)'(stk.size());
  endtask

  task automatic resetDut();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Reference: kind 0 = select completes, 1 = drop completes, 2 = trap.
  task automatic predict(input logic [7:0] op, output int kind, output logic [2:0] tc, output logic [63:0] res);
    kind = 2;
    tc   = 3'd0;
    res  = '0;
    if (op != 8'h1A && op != 8'h1B) tc = 3'd5;
    else if ((op == 8'h1B && stk.size() < 3) || (op == 8'h1A && stk.size() < 1)) tc = 3'd3;
    else if (op == 8'h1A) kind = 1;
    else begin
      kind = 0;
      res  = (stk[0][31:0] != 32'd0) ? stk[2] : stk[1];
    end
  endtask

  // Expected {pop, push, done, trap, ready} k cycles after the accept cycle.
  function automatic logic [6:0] expCycle(input int kind, input logic [2:0] tc, input int k);
    logic pop, push, done, ready;
    logic [2:0] t;
    pop   = (kind == 0 && k >= 1 && k <= 3) || (kind == 1 && k == 1);
    push  = (kind == 0 && k == 5);
    done  = (kind == 0 && k == 5) || (kind == 1 && k == 2);
    t     = (kind == 2 && k >= 2) ? tc : 3'd0;
    ready = (kind == 0 && k >= 6) || (kind == 1 && k >= 3);
    return {pop, push, done, t, ready};
  endfunction

  function automatic logic [6:0] actCycle();
    return {bus.stack_pop, bus.stack_push, bus.done, bus.trap, bus.op_ready};
  endfunction

  task automatic applyStimulus(input string tag, input logic [7:0] op, input int kind,
                               input logic [2:0] tc, input logic [63:0] res, input int pulseK);
    logic [63:0] post[$];
    logic [6:0]  e;
    post = stk;
    if (kind == 0) begin
      void'(post.pop_front());
      void'(post.pop_front());
      void'(post.pop_front());
      post.push_front(res);
    end else if (kind == 1) begin
      void'(post.pop_front());
    end
    checkOutput({tag, " ready_before"}, 64'(bus.op_ready), 64'd1);
    bus.op_valid = 1'b1;
    bus.opcode   = op;
    tick();
    bus.op_valid = 1'b0;
    bus.opcode   = 8'($urandom);
    for (int k = 1; k <= 7; k++) begin
      e = expCycle(kind, tc, k);
      checkOutput($sformatf("%s cycle%0d {pop,push,done,trap,ready}", tag, k), 64'(actCycle()), 64'(e));
      if (e[5]) checkOutput($sformatf("%s din", tag), bus.stack_din, res);
      if (k == pulseK && !e[0]) begin
        bus.op_valid = 1'b1;
        bus.opcode   = 8'h1C;
      end
      tick();
      bus.op_valid = 1'b0;
    end
    checkOutput({tag, " stack_size"}, 64'(stk.size()), 64'(post.size()));
    if (post.size() > 0 && stk.size() > 0)
      checkOutput({tag, " stack_top"}, stk[0], post[0]);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          kind;
    logic [2:0]  tc;
    logic [63:0] res;
    logic [63:0] c;
    int          size;
    int          pushes;
    logic [7:0]  op;

    vecs[0] = '{8'h1B, 3,  64'h1, 64'h2, 64'h1, 0, 3'd0, 64'h1, 4};
    vecs[1] = '{8'h1B, 3,  64'h1_0000_0000, 64'hBEEF, 64'hCAFE, 0, 3'd0, 64'hBEEF, 0};
    vecs[2] = '{8'h1A, 1,  64'h77, 64'h0, 64'h0, 1, 3'd0, 64'h0, 1};
    vecs[3] = '{8'h1B, 2,  64'h1, 64'h2, 64'h0, 2, 3'd3, 64'h0, 3};
    vecs[4] = '{8'h1C, 3,  64'h1, 64'h2, 64'h3, 2, 3'd5, 64'h0, 0};
    vecs[5] = '{8'h1A, 0,  64'h0, 64'h0, 64'h0, 2, 3'd3, 64'h0, 2};
    vecs[6] = '{8'h1B, 31, 64'hFFFF_FFFF_0000_0000, 64'hAAA, 64'hBBB, 0, 3'd0, 64'hAAA, 2};
    vecs[7] = '{8'h1A, 31, 64'h5, 64'h6, 64'h7, 1, 3'd0, 64'h0, 0};
    vecs[8] = '{8'h1B, 4,  64'h8000_0000, 64'h1234, 64'h5678, 0, 3'd0, 64'h5678, 5};

    reset          = 1'b0;
    bus.op_valid   = 1'b0;
    bus.opcode     = 8'h00;
    bus.stack_dout = '0;
    bus.stack_size = '0;
`ifdef SELECT_TRAP_CLEAR_EN
    trap_clear     = 1'b0;
`endif
    tick();
    checkOutput("reset {pop,push,done,trap,ready}", 64'(actCycle()), 64'b0000001);
    checkOutput("reset din", bus.stack_din, 64'h0);
    reset = 1'b1;
    tick();

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      loadStack(vecs[i].size, vecs[i].e0, vecs[i].e1, vecs[i].e2);
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].kind, vecs[i].tc, vecs[i].din, vecs[i].pulseK);
      if (vecs[i].kind == 2) resetDut();
    end

`ifdef SELECT_TRAP_CLEAR_EN
    $display("[TB] trap_clear sequence");
    loadStack(2, 64'h1, 64'h2, 64'h0);
    applyStimulus("clr_underflow", 8'h1B, 2, 3'd3, 64'h0, 0);
    trap_clear = 1'b1;
    tick();
    trap_clear = 1'b0;
    checkOutput("trap_clear {pop,push,done,trap,ready}", 64'(actCycle()), 64'b0000001);
    trap_clear = 1'b1;
    tick();
    trap_clear = 1'b0;
    checkOutput("trap_clear idle {pop,push,done,trap,ready}", 64'(actCycle()), 64'b0000001);
`endif

    $display("[TB] reset during POP_V1");
    loadStack(3, 64'h5, 64'h11, 64'h22);
    bus.op_valid = 1'b1;
    bus.opcode   = 8'h1B;
    tick();
    bus.op_valid = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset pop", 64'(bus.stack_pop), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("async_reset {pop,push,done,trap,ready}", 64'(actCycle()), 64'b0000001);
    checkOutput("async_reset din", bus.stack_din, 64'h0);
    tick();
    reset = 1'b1;
    pushes = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.stack_push) pushes++;
      tick();
    end
    checkOutput("no_push_after_reset", 64'(pushes), 64'd0);
    checkOutput("stack_after_abort", 64'(stk.size()), 64'd1);
    loadStack(3, 64'h0, 64'h99, 64'h42);
    applyStimulus("after_reset_select", 8'h1B, 0, 3'd0, 64'h99, 0);

    $display("[TB] random ops");
    for (int n = 0; n < 40; n++) begin
      size = ($urandom_range(0, 9) == 9) ? 31 : $urandom_range(0, 4);
      c    = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) c[31:0] = 32'd0;
      loadStack(size, c, {$urandom, $urandom}, {$urandom, $urandom});
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 8'h1B;
        4, 5, 6, 7: op = 8'h1A;
        default:    op = 8'($urandom);
      endcase
      predict(op, kind, tc, res);
      applyStimulus($sformatf("rand%0d", n), op, kind, tc, res, $urandom_range(0, 5));
      if (kind == 2) resetDut();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
